// File: rtl/hd63701_sci.sv
// HD63701 serial communication interface: RMCR/TRCSR/RDR/TDR register block
// with an 8N1 transmitter and a mid-bit sampling receiver.
module hd63701_sci #(
    parameter logic [15:0] BASE = 16'h0010
) (
    input  logic        mcu_clx2,
    input  logic        mcu_rst,
    input  logic [15:0] mcu_ad,
    input  logic        mcu_wr,
    input  logic        mcu_rd,
    input  logic [7:0]  mcu_do,
    output logic        en_sci,
    output logic [7:0]  scid,
    output logic        sci_irq,
    input  logic        rxd,
    output logic        txd
);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [15:0] offset;
    logic        wr_rmcr, wr_trcsr, wr_tdr;
    logic        rd_trcsr, rd_rdr, rd_clear;

    logic [3:0]  rmcr;
    logic [4:0]  ctl;
    logic        rie, re, tie, te;
    logic [7:0]  rdr, tdr;
    logic        rdrf, orfe, tdre, arm;

    logic [12:0] per_m1, half_m1;

    tx_state_t   tx_state, tx_next;
    logic [12:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_sh;
    logic        tx_end, tx_load, tx_restart, tx_shift, tx_bit_clr;

    rx_state_t   rx_state, rx_next;
    logic [12:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh;
    logic        rx_sync1, rx_s, rx_prev, rx_fall, rx_end;
    logic        rx_restart, rx_restart_half, rx_sample, rx_bit_clr, rx_done;
    logic        rx_load, rx_err;

    // Address decode: the subtraction wraps, so one range test covers BASE..BASE+3.
    assign offset   = mcu_ad - BASE;
    assign en_sci   = (offset[15:2] == '0);
    assign wr_rmcr  = mcu_wr & en_sci & (offset[1:0] == 2'd0);
    assign wr_trcsr = mcu_wr & en_sci & (offset[1:0] == 2'd1);
    assign wr_tdr   = mcu_wr & en_sci & (offset[1:0] == 2'd3);
    assign rd_trcsr = mcu_rd & en_sci & (offset[1:0] == 2'd1);
    assign rd_rdr   = mcu_rd & en_sci & (offset[1:0] == 2'd2);
    assign rd_clear = rd_rdr & arm;

    assign rie = ctl[4];
    assign re  = ctl[3];
    assign tie = ctl[2];
    assign te  = ctl[1];

    always_comb begin
        scid = '0;
        if (en_sci) begin
            case (offset[1:0])
                2'd0:    scid = {4'h0, rmcr};
                2'd1:    scid = {rdrf, orfe, tdre, ctl};
                2'd2:    scid = rdr;
                default: scid = tdr;
            endcase
        end
    end

    assign sci_irq = (rie & (rdrf | orfe)) | (tie & tdre);

    always_comb begin
        case (rmcr[1:0])
            2'd0:    begin per_m1 = 13'd31;   half_m1 = 13'd15;   end
            2'd1:    begin per_m1 = 13'd255;  half_m1 = 13'd127;  end
            2'd2:    begin per_m1 = 13'd2047; half_m1 = 13'd1023; end
            default: begin per_m1 = 13'd8191; half_m1 = 13'd4095; end
        endcase
    end

    always_ff @(posedge mcu_clx2 or posedge mcu_rst) begin
        if (mcu_rst) begin
            rmcr <= '0;
            ctl  <= '0;
            rdr  <= '0;
            tdr  <= '0;
            rdrf <= 1'b0;
            orfe <= 1'b0;
            tdre <= 1'b1;
            arm  <= 1'b0;
        end else begin
            if (wr_rmcr)  rmcr <= mcu_do[3:0];
            if (wr_trcsr) ctl  <= mcu_do[4:0];
            if (wr_tdr)   tdr  <= mcu_do;
            if (rx_load)  rdr  <= rx_sh;
            // Flag sets take priority over same-cycle clears.
            if (tx_load)     tdre <= 1'b1;
            else if (wr_tdr) tdre <= 1'b0;
            if (rx_load)       rdrf <= 1'b1;
            else if (rd_clear) rdrf <= 1'b0;
            if (rx_err)        orfe <= 1'b1;
            else if (rd_clear) orfe <= 1'b0;
            if (rd_rdr)                       arm <= 1'b0;
            else if (rd_trcsr & (rdrf | orfe)) arm <= 1'b1;
        end
    end

    assign tx_end = (tx_cnt == '0);

    always_comb begin
        tx_next    = tx_state;
        tx_load    = 1'b0;
        tx_restart = 1'b0;
        tx_shift   = 1'b0;
        tx_bit_clr = 1'b0;
        txd        = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (te && !tdre) begin
                    tx_next    = TX_START;
                    tx_load    = 1'b1;
                    tx_restart = 1'b1;
                end
            end
            TX_START: begin
                txd = 1'b0;
                if (tx_end) begin
                    tx_next    = TX_DATA;
                    tx_restart = 1'b1;
                    tx_bit_clr = 1'b1;
                end
            end
            TX_DATA: begin
                txd = tx_sh[0];
                if (tx_end) begin
                    tx_restart = 1'b1;
                    if (tx_bit == 3'd7) tx_next  = TX_STOP;
                    else                tx_shift = 1'b1;
                end
            end
            default: begin
                if (tx_end) begin
                    if (te && !tdre) begin
                        tx_next    = TX_START;
                        tx_load    = 1'b1;
                        tx_restart = 1'b1;
                    end else begin
                        tx_next = TX_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge mcu_clx2 or posedge mcu_rst) begin
        if (mcu_rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
        end else begin
            tx_state <= tx_next;
            if (tx_restart)   tx_cnt <= per_m1;
            else if (!tx_end) tx_cnt <= tx_cnt - 13'd1;
            if (tx_load) tx_sh <= tdr;
            if (tx_bit_clr) begin
                tx_bit <= '0;
            end else if (tx_shift) begin
                tx_sh  <= {1'b0, tx_sh[7:1]};
                tx_bit <= tx_bit + 3'd1;
            end
        end
    end

    always_ff @(posedge mcu_clx2 or posedge mcu_rst) begin
        if (mcu_rst) begin
            rx_sync1 <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b1;
        end else begin
            rx_sync1 <= rxd;
            rx_s     <= rx_sync1;
            rx_prev  <= rx_s;
        end
    end

    assign rx_fall = rx_prev & ~rx_s;
    assign rx_end  = (rx_cnt == '0);

    always_comb begin
        rx_next         = rx_state;
        rx_restart      = 1'b0;
        rx_restart_half = 1'b0;
        rx_sample       = 1'b0;
        rx_bit_clr      = 1'b0;
        rx_done         = 1'b0;
        if (!re) begin
            rx_next = RX_IDLE;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_next         = RX_START;
                        rx_restart_half = 1'b1;
                    end
                end
                RX_START: begin
                    if (rx_end) begin
                        if (rx_s) begin
                            rx_next = RX_IDLE;
                        end else begin
                            rx_next    = RX_DATA;
                            rx_restart = 1'b1;
                            rx_bit_clr = 1'b1;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_end) begin
                        rx_sample  = 1'b1;
                        rx_restart = 1'b1;
                        if (rx_bit == 3'd7) rx_next = RX_STOP;
                    end
                end
                default: begin
                    if (rx_end) begin
                        rx_done = 1'b1;
                        rx_next = RX_IDLE;
                    end
                end
            endcase
        end
    end

    assign rx_load = rx_done & rx_s & ~rdrf;
    assign rx_err  = rx_done & (~rx_s | rdrf);

    always_ff @(posedge mcu_clx2 or posedge mcu_rst) begin
        if (mcu_rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            rx_state <= rx_next;
            if (rx_restart_half) rx_cnt <= half_m1;
            else if (rx_restart) rx_cnt <= per_m1;
            else if (!rx_end)    rx_cnt <= rx_cnt - 13'd1;
            if (rx_bit_clr) begin
                rx_bit <= '0;
            end else if (rx_sample) begin
                rx_sh  <= {rx_s, rx_sh[7:1]};
                rx_bit <= rx_bit + 3'd1;
            end
        end
    end

endmodule
